// File: rtl/mdu_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// mdu_pkg : shared types and constants for the MDU divider
// Rev 1.0
//----------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Magnitude quotient produced by a divide by zero, before sign fixup
  localparam logic [MDU_WIDTH-1:0] MDU_DIV0_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_abs_neg.sv
`default_nettype none
//----------------------------------------------------------------------------
// mdu_abs_neg : combinational conditional two's-complement negate
// Rev 1.0
//----------------------------------------------------------------------------
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
//----------------------------------------------------------------------------
// mdu_divider : radix-2 restoring DIV/DIVU unit with sign-fixup cycle
// Option: MDU_DIV_FAST_ZERO_EN (single-cycle divide by zero).  Rev 1.0
//----------------------------------------------------------------------------
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_ena_i,
  input  logic             divu_ena_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;

  logic             w_accept;
  logic             w_qneg;
  logic             w_rneg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dq_d;
  logic             w_fast_zero;
  logic [WIDTH-1:0] w_div0_q;

  assign w_accept  = start_i & (div_ena_i | divu_ena_i) &
                     ((state_q == IDLE) | (state_q == DONE));
  assign w_qneg    = div_ena_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
  assign w_rneg    = div_ena_i & dividend_i[WIDTH-1];
  assign w_dvs_neg = div_ena_i & divisor_i[WIDTH-1];

  mdu_abs_neg #(.WIDTH(WIDTH)) u_dvd_abs (.a_i(dividend_i), .neg_i(w_rneg),    .y_o(w_dvd_mag));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_dvs_abs (.a_i(divisor_i),  .neg_i(w_dvs_neg), .y_o(w_dvs_mag));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_q_fix   (.a_i(dq_q),       .neg_i(qneg_q),    .y_o(w_q_fix));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_r_fix   (.a_i(rem_q),      .neg_i(rneg_q),    .y_o(w_r_fix));

  // dq_q shifts dividend bits out of the top and quotient bits in at the bottom
  assign w_rem_sh = {rem_q, dq_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, dvs_q};
  assign w_qbit   = ~w_diff[WIDTH];
  assign rem_d    = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign dq_d     = {dq_q[WIDTH-2:0], w_qbit};

`ifdef MDU_DIV_FAST_ZERO_EN
  assign w_fast_zero = (divisor_i == '0);
  assign w_div0_q    = w_qneg ? WIDTH'(1) : {WIDTH{MDU_DIV0_Q[0]}};
`else
  assign w_fast_zero = 1'b0;
  assign w_div0_q    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CALC: begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          q_q     <= w_q_fix;
          r_q     <= w_r_fix;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          if (w_accept) begin
            qneg_q <= w_qneg;
            rneg_q <= w_rneg;
            dvs_q  <= w_dvs_mag;
            dq_q   <= w_dvd_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (w_fast_zero) begin
              // -|x| carrying x's own sign is x, so the remainder is the raw dividend
              q_q     <= w_div0_q;
              r_q     <= dividend_i;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
      endcase
    end
  end

  assign q_o    = q_q;
  assign r_o    = r_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_divider.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_mdu_divider : directed + random checks of mdu_divider against a
// magnitude/sign arithmetic model.  Rev 1.0
//----------------------------------------------------------------------------
module tb_mdu_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         div_ena_i;
  logic         divu_ena_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic [W-1:0] q_o;
  logic [W-1:0] r_o;
  logic         busy_o;
  logic         done_o;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  int           exp_lat;

  mdu_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .div_ena_i  (div_ena_i),
    .divu_ena_i (divu_ena_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .q_o        (q_o),
    .r_o        (r_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Divide magnitudes as plain integers, then apply the MIPS sign rules
  function automatic void model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    logic [63:0] am, bm, qm, rm;
    bit an, bn;
    an = sgn && a[W-1];
    bn = sgn && b[W-1];
    am = an ? ((64'd1 << W) - 64'(a)) : 64'(a);
    bm = bn ? ((64'd1 << W) - 64'(b)) : 64'(b);
    if (bm == 64'd0) begin
      qm = (64'd1 << W) - 64'd1;
      rm = am;
    end else begin
      qm = am / bm;
      rm = am % bm;
    end
    q = (an != bn) ? W'(64'd0 - qm) : W'(qm);
    r = an ? W'(64'd0 - rm) : W'(rm);
  endfunction

  // mode: 0 = DIVU, 1 = DIV, 2 = both selects (signed expected)
  task automatic issue(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i    = 1'b1;
    div_ena_i  = (mode != 0);
    divu_ena_i = (mode != 1);
    dividend_i = a;
    divisor_i  = b;
    model(mode != 0, a, b, exp_q, exp_r);
    exp_lat = LAT;
`ifdef MDU_DIV_FAST_ZERO_EN
    if (b == '0) exp_lat = 1;
`endif
    @(posedge clk);
    @(negedge clk);
    start_i    = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    div_ena_i  = 1'($urandom % 2);
    divu_ena_i = 1'($urandom % 2);
  endtask

  // Called in cycle 1 after the accepting edge; returns in the done cycle
  task automatic finish_op(input string tag, input int inj, input bit hold,
                           input logic [W-1:0] hq, input logic [W-1:0] hr);
    int n = 1;
    int nb = 0;
    bit hold_bad = 1'b0;
    while (done_o !== 1'b1 && n < 3 * LAT) begin
      if (busy_o === 1'b1) nb++;
      if (hold && (q_o !== hq || r_o !== hr)) hold_bad = 1'b1;
      if (n == inj) begin
        start_i    = 1'b1;
        div_ena_i  = 1'b1;
        dividend_i = $urandom;
        divisor_i  = $urandom | 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    chk({tag, "_done"},      W'(done_o),  W'(1));
    chk({tag, "_latency"},   W'(n),       W'(exp_lat));
    chk({tag, "_busy_cyc"},  W'(nb),      W'(exp_lat - 1));
    chk({tag, "_busy_done"}, W'(busy_o),  W'(0));
    chk({tag, "_q"},         q_o,         exp_q);
    chk({tag, "_r"},         r_o,         exp_r);
    if (hold) chk({tag, "_hold"}, W'(hold_bad), W'(0));
  endtask

  initial begin
    logic [W-1:0] qa, ra, a, b;
    bit saw_done;

    rst_n = 1'b0; start_i = 1'b0; div_ena_i = 1'b0; divu_ena_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", q_o, '0);
    chk("rst_r", r_o, '0);
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_done", W'(done_o), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // start with neither select must not launch anything
    start_i = 1'b1; dividend_i = 32'd5; divisor_i = 32'd1;
    @(negedge clk);
    start_i = 1'b0;
    chk("nosel_busy", W'(busy_o), W'(0));
    chk("nosel_done", W'(done_o), W'(0));
    @(negedge clk);
    chk("nosel_busy2", W'(busy_o), W'(0));

    issue(0, 32'd100, 32'd7);
    finish_op("divu_100_7", 0, 1'b0, '0, '0);
    chk("divu_100_7_qk", q_o, 32'd14);
    chk("divu_100_7_rk", r_o, 32'd2);

    issue(1, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 0, 1'b0, '0, '0);
    chk("div_m7_2_qk", q_o, 32'hFFFF_FFFD);
    chk("div_m7_2_rk", r_o, 32'hFFFF_FFFF);

    issue(1, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_7_m2", 0, 1'b0, '0, '0);
    chk("div_7_m2_qk", q_o, 32'hFFFF_FFFD);
    chk("div_7_m2_rk", r_o, 32'd1);

    issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 0, 1'b0, '0, '0);
    chk("div_ovf_qk", q_o, 32'h8000_0000);
    chk("div_ovf_rk", r_o, 32'd0);

    issue(0, 32'h1234, 32'd0);
    finish_op("divu_z", 0, 1'b0, '0, '0);
    chk("divu_z_qk", q_o, 32'hFFFF_FFFF);
    chk("divu_z_rk", r_o, 32'h1234);

    issue(1, 32'hFFFF_FFF9, 32'd0);
    finish_op("div_z", 0, 1'b0, '0, '0);

    issue(2, 32'hFFFF_FFF9, 32'd2);
    finish_op("both_sel", 0, 1'b0, '0, '0);

    issue(0, 32'd1000, 32'd3);
    finish_op("ign_start", 10, 1'b0, '0, '0);

    // back-to-back: second accept lands in the first op's done cycle
    issue(0, 32'hDEAD_BEEF, 32'h10);
    finish_op("b2b_a", 0, 1'b0, '0, '0);
    qa = q_o;
    ra = r_o;
    issue(1, 32'hFFFF_FF9C, 32'd9);
    finish_op("b2b_b", 0, 1'b1, qa, ra);

    // asynchronous reset in cycle 20 aborts the operation
    issue(0, 32'hFFFF_0000, 32'd3);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy_o), W'(0));
    chk("midrst_done", W'(done_o), W'(0));
    chk("midrst_q", q_o, '0);
    chk("midrst_r", r_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_nodone", W'(saw_done), W'(0));

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if ($urandom % 5 == 0) a = 32'h8000_0000;
      case ($urandom % 4)
        0:       b = '0;
        1:       b = W'($urandom % 16 + 1);
        2:       b = -W'($urandom % 16 + 1);
        default: b = $urandom;
      endcase
      issue(int'($urandom % 3), a, b);
      finish_op("rand", 0, 1'b0, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
